// File: rtl/wb_csr_bridge_pkg.sv
// Shared CSR-bus definitions for the Wishbone-to-CSR bridge and the CSR slaves
// (address/data widths, bank field position, bridge FSM states).
package wb_csr_bridge_pkg;

    localparam int unsigned CsrAw      = 14;
    localparam int unsigned CsrDw      = 32;
    localparam int unsigned CsrBankMsb = 13;
    localparam int unsigned CsrBankLsb = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StAck
    } bridge_state_e;

    // Bank index of a Wishbone byte address (csr_a[13:10] == wb_adr[15:12]).
    function automatic logic [3:0] wb_bank(input logic [31:0] adr);
        return adr[CsrBankMsb+2:CsrBankLsb+2];
    endfunction

endpackage

// File: rtl/wb_csr_bridge.sv
// Wishbone slave to CSR-bus master: one CSR cycle per single WB access.
// Optional address checking with bus error is enabled by defining WB_CSR_BRIDGE_ERR_EN.
module wb_csr_bridge
    import wb_csr_bridge_pkg::*;
#(
    parameter int unsigned read_wait  = 1,
    parameter int unsigned write_wait = 0,
    parameter int unsigned nbanks     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,

    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    output logic             wb_ack_o,
    output logic             wb_err_o,

    output logic [CsrAw-1:0] csr_a,
    output logic             csr_we,
    output logic [CsrDw-1:0] csr_do,
    input  logic [CsrDw-1:0] csr_di
);

    localparam logic [1:0] ReadCnt  = 2'(read_wait);
    localparam logic [1:0] WriteCnt = 2'(write_wait);

    bridge_state_e    state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;
    logic [CsrDw-1:0] dat_q, dat_d;
    logic [CsrAw-1:0] csr_a_q, csr_a_d;
    logic             csr_we_q, csr_we_d;
    logic [CsrDw-1:0] csr_do_q, csr_do_d;

    logic req;
    logic req_err;
    logic done;
    logic unused_adr;

    assign unused_adr = ^{wb_adr_i[31:16], wb_adr_i[1:0]};

`ifdef WB_CSR_BRIDGE_ERR_EN
    assign req_err = ({28'd0, wb_bank(wb_adr_i)} >= 32'(nbanks)) || (wb_adr_i[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    assign req  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign done = (cnt_q == 2'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        abort_d  = abort_q;
        dat_d    = dat_q;
        csr_a_d  = csr_a_q;
        csr_we_d = 1'b0;
        csr_do_d = csr_do_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (req_err) begin
                        // Rejected: no CSR cycle, just a one-cycle error through StAck.
                        err_d   = 1'b1;
                        state_d = StAck;
                    end else begin
                        csr_a_d = wb_adr_i[15:2];
                        abort_d = 1'b0;
                        if (wb_we_i) begin
                            csr_do_d = wb_dat_i;
                            csr_we_d = 1'b1;
                            cnt_d    = WriteCnt;
                            state_d  = StWrite;
                        end else begin
                            cnt_d   = ReadCnt;
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: begin
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (done) begin
                    ack_d   = wb_cyc_i & ~abort_q;
                    state_d = StAck;
                    if (wb_cyc_i && !abort_q) begin
                        dat_d = csr_di;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StWrite: begin
                // An aborted cycle still runs to completion; only the ack is withheld.
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (done) begin
                    ack_d   = wb_cyc_i & ~abort_q;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StAck: begin
                dat_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 2'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
            dat_q    <= '0;
            csr_a_q  <= '0;
            csr_we_q <= 1'b0;
            csr_do_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
            dat_q    <= dat_d;
            csr_a_q  <= csr_a_d;
            csr_we_q <= csr_we_d;
            csr_do_q <= csr_do_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign csr_a    = csr_a_q;
    assign csr_we   = csr_we_q;
    assign csr_do   = csr_do_q;

endmodule
